// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : Memory-stage to write-back-stage handshake bundle. Carries
//                the valid/ready pair plus every field of the instruction
//                handed to write-back.
//                master : memory stage (drives instruction, samples ready)
//                slave  : write-back stage (samples instruction, drives ready)
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_last;
    logic                  ready_last;
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic                  R_wen;
    logic [4:0]            rd;
    logic                  mem_ren;
    logic [DATA_WIDTH-1:0] MEM_Rdata;
    logic [DATA_WIDTH-1:0] Ex_result;
    logic [3:0]            csr_wen;
    logic [DATA_WIDTH-1:0] csrs;
    logic                  jump_flag;

    modport master (
        output valid_last, pc, inst, R_wen, rd, mem_ren, MEM_Rdata,
               Ex_result, csr_wen, csrs, jump_flag,
        input  ready_last
    );

    modport slave (
        input  valid_last, pc, inst, R_wen, rd, mem_ren, MEM_Rdata,
               Ex_result, csr_wen, csrs, jump_flag,
        output ready_last
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Write-back stage of the 5-stage RV32 pipeline. Registers one
//                instruction from the memory stage, selects load data or the
//                execute result, writes the integer register file and the
//                four machine CSRs (mstatus, mtvec, mepc, mcause).
//  Ports       : clk, rst             clock, synchronous active-high reset
//                mem_if (slave)       instruction handshake from memory stage
//                raddr1/2, rdata1/2   combinational decode read ports
//                *_o                  current CSR values
//                fwd_*                forwarding view of retiring instruction
//                commit_*             commit view of retiring instruction
//                retire_cnt           64-bit retired-instruction counter
//  Options     : WB_RETIRE_CNT_EN     when defined, retire_cnt counts retired
//                                     instructions; otherwise tied to 0
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    REG_NUM     = 32,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] MSTATUS_RST = 32'h0000_1800
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    wb_stage_if.slave                  mem_if,
    input  wire logic [4:0]            raddr1,
    input  wire logic [4:0]            raddr2,
    output logic      [DATA_WIDTH-1:0] rdata1,
    output logic      [DATA_WIDTH-1:0] rdata2,
    output logic      [DATA_WIDTH-1:0] mstatus_o,
    output logic      [DATA_WIDTH-1:0] mtvec_o,
    output logic      [DATA_WIDTH-1:0] mepc_o,
    output logic      [DATA_WIDTH-1:0] mcause_o,
    output logic                       fwd_valid,
    output logic      [4:0]            fwd_rd,
    output logic      [DATA_WIDTH-1:0] fwd_data,
    output logic                       commit_valid,
    output logic      [31:0]           commit_pc,
    output logic      [31:0]           commit_inst,
    output logic                       commit_jump,
    output logic      [63:0]           retire_cnt
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                  r_wb_valid;
    logic [31:0]           r_pc;
    logic [31:0]           r_inst;
    logic                  r_R_wen;
    logic [4:0]            r_rd;
    logic                  r_mem_ren;
    logic [DATA_WIDTH-1:0] r_MEM_Rdata;
    logic [DATA_WIDTH-1:0] r_Ex_result;
    logic [3:0]            r_csr_wen;
    logic [DATA_WIDTH-1:0] r_csrs;
    logic                  r_jump_flag;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_fwd_valid;

    // No stall path: write-back always drains in one cycle.
    assign mem_if.ready_last = 1'b1;
    assign w_accept          = mem_if.valid_last & mem_if.ready_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_R_wen     <= 1'b0;
            r_rd        <= '0;
            r_mem_ren   <= 1'b0;
            r_MEM_Rdata <= '0;
            r_Ex_result <= '0;
            r_csr_wen   <= '0;
            r_csrs      <= '0;
            r_jump_flag <= 1'b0;
        end else if (w_accept) begin
            r_wb_valid  <= 1'b1;
            r_pc        <= mem_if.pc;
            r_inst      <= mem_if.inst;
            r_R_wen     <= mem_if.R_wen;
            r_rd        <= mem_if.rd;
            r_mem_ren   <= mem_if.mem_ren;
            r_MEM_Rdata <= mem_if.MEM_Rdata;
            r_Ex_result <= mem_if.Ex_result;
            r_csr_wen   <= mem_if.csr_wen;
            r_csrs      <= mem_if.csrs;
            r_jump_flag <= mem_if.jump_flag;
        end else begin
            // Payload is held; only the valid flag drops.
            r_wb_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Retire-cycle datapath
    // ------------------------------------------------------------------
    assign w_wb_data   = r_mem_ren ? r_MEM_Rdata : r_Ex_result;
    assign w_fwd_valid = r_wb_valid & r_R_wen & (r_rd != 5'd0);

    assign fwd_valid    = w_fwd_valid;
    assign fwd_rd       = r_rd;
    assign fwd_data     = w_wb_data;
    assign commit_valid = r_wb_valid;
    assign commit_pc    = r_pc;
    assign commit_inst  = r_inst;
    assign commit_jump  = r_jump_flag;

    // ------------------------------------------------------------------
    // Integer register file. Entry 0 is only ever written with zero (reset)
    // because w_fwd_valid excludes rd == 0, and reads of x0 are forced to 0.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_rf [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_fwd_valid) begin
            r_rf[r_rd] <= w_wb_data;
        end
    end

    // Write-through bypass lets decode see the retiring value in the same
    // cycle the write is still pending.
    always_comb begin
        rdata1 = '0;
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (w_fwd_valid && (raddr1 == r_rd)) begin
            rdata1 = w_wb_data;
        end else begin
            rdata1 = r_rf[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (w_fwd_valid && (raddr2 == r_rd)) begin
            rdata2 = w_wb_data;
        end else begin
            rdata2 = r_rf[raddr2];
        end
    end

    // ------------------------------------------------------------------
    // Machine CSRs: every enabled CSR takes the same value csrs.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mstatus;
    logic [DATA_WIDTH-1:0] r_mtvec;
    logic [DATA_WIDTH-1:0] r_mepc;
    logic [DATA_WIDTH-1:0] r_mcause;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus <= MSTATUS_RST;
            r_mtvec   <= MTVEC_RST;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else if (r_wb_valid) begin
            if (r_csr_wen[0]) r_mstatus <= r_csrs;
            if (r_csr_wen[1]) r_mtvec   <= r_csrs;
            if (r_csr_wen[2]) r_mepc    <= r_csrs;
            if (r_csr_wen[3]) r_mcause  <= r_csrs;
        end
    end

    assign mstatus_o = r_mstatus;
    assign mtvec_o   = r_mtvec;
    assign mepc_o    = r_mepc;
    assign mcause_o  = r_mcause;

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (r_wb_valid) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = 64'd0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage RV32 pipeline. Sits directly downstream of the memory stage and consumes its outputs through the valid/ready handshake.
- Registers one instruction, selects load data or execute result, and writes the integer register file and the machine CSRs.
- Owns the 32x32 register file (two combinational read ports for decode) and the four machine CSRs.
- Provides a forwarding/commit view of the instruction currently retiring.

Parameters:
- DATA_WIDTH, 32, datapath and register width.
- REG_NUM, 32, number of integer registers; x0 is hardwired to zero.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MSTATUS_RST, 32'h0000_1800, reset value of mstatus (MPP=11).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_last  in  1  memory stage has an instruction.
- ready_last  out  1  write-back can accept; tied to 1.
- pc  in  32  pc of the incoming instruction.
- inst  in  32  instruction word.
- R_wen  in  1  integer register write enable.
- rd  in  5  destination register.
- mem_ren  in  1  instruction is a load; selects MEM_Rdata.
- MEM_Rdata  in  32  extended load data.
- Ex_result  in  32  ALU/jump-link result.
- csr_wen  in  4  per-CSR write enable: bit0 mstatus, bit1 mtvec, bit2 mepc, bit3 mcause.
- csrs  in  32  value written to every CSR whose enable bit is set.
- jump_flag  in  1  instruction redirected the pc.
- raddr1, raddr2  in  5 each  decode read addresses.
- rdata1, rdata2  out  32 each  decode read data.
- mstatus_o, mtvec_o, mepc_o, mcause_o  out  32 each  current CSR values.
- fwd_valid  out  1  retiring instruction writes a nonzero rd.
- fwd_rd  out  5  its rd.
- fwd_data  out  32  its write-back data.
- commit_valid  out  1  one instruction retires this cycle.
- commit_pc, commit_inst  out  32 each  retiring pc and instruction.
- commit_jump  out  1  retiring jump_flag.
- retire_cnt  out  64  retired-instruction counter.

Behaviour:
- Capture: on an edge with valid_last & ready_last, all inputs load into the stage registers and wb_valid is set to 1. On an edge with no handshake, wb_valid is cleared to 0. No stall path exists.
- Retire cycle: the cycle in which wb_valid = 1.
  - commit_valid = wb_valid.
  - wb_data = mem_ren_reg ? MEM_Rdata_reg : Ex_result_reg.
  - fwd_valid = wb_valid & R_wen_reg & (rd_reg != 0); fwd_rd = rd_reg; fwd_data = wb_data.
- Register file: written at the edge that ends the retire cycle, when fwd_valid = 1.
  - Latency from handshake edge to architectural write: 2 edges.
- Read ports: combinational.
  - raddr = 0 returns 0.
  - raddr equal to fwd_rd while fwd_valid = 1 returns fwd_data (write-through bypass).
  - Otherwise returns the array contents.
- CSRs: at the same edge, each CSR whose csr_wen_reg bit is set loads csrs_reg, gated by wb_valid.
  - Several bits may be set at once; all selected CSRs take the same value.
  - An instruction may write both a register and CSRs.
- Reset: the following are forced at the reset edge; a pending entry is discarded and never written:
  - wb_valid = 0; all stage registers = 0.
  - Register file cleared to 0.
  - mstatus = MSTATUS_RST, mtvec = MTVEC_RST, mepc = 0, mcause = 0.
  - retire_cnt = 0.
- Output values in reset: commit_*, fwd_* and rdata* follow the cleared state, so all are 0.
- Back-to-back: a new capture in the same edge as a retire write is legal. Throughput is 1 instruction/cycle.
- R_wen with rd = 0: no write, fwd_valid = 0, commit still asserted.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt is a 64-bit counter, +1 at each edge ending a retire cycle. Wraps from 2^64-1 to 0. Cleared by rst.
- Undefined: no counter logic; retire_cnt is tied to 0.

Test Plan:
- Reset, then raddr1=5 -> rdata1=0; mtvec_o=MTVEC_RST; mstatus_o=32'h1800; commit_valid=0.
- Handshake with R_wen=1, rd=3, mem_ren=0, Ex_result=32'h1234 -> next cycle: commit_valid=1, fwd_valid=1, fwd_data=32'h1234, rdata1 (raddr1=3) = 32'h1234 via bypass. From the following cycle, array read also returns 32'h1234.
- Load with mem_ren=1, MEM_Rdata=32'hFFFF_FF80, Ex_result=32'h8000_0000, rd=7 -> x7=32'hFFFF_FF80.
- Write with rd=0, Ex_result=32'hDEAD -> fwd_valid=0, x0 stays 0, commit_valid=1.
- csr_wen=4'b1100, csrs=32'h8000_0010 -> mepc_o=mcause_o=32'h8000_0010; mstatus and mtvec unchanged.
- rst asserted in the cycle after a handshake with rd=9, Ex_result=32'h55 -> x9 stays 0, commit_valid=0. With WB_RETIRE_CNT_EN, 3 back-to-back instructions -> retire_cnt=3.
